ieee_fp_div: RTL
================

Name: ieee_fp_div

Overview:
- Sequential floating-point divider, z = x / y. Companion to the team's sequential FP multiplier.
- Uses the same packed format: sign | exponent (excess 2^(EBITS-1)-1) | fraction with hidden bit.
- Uses the same special-value conventions as the multiplier.
- Unpacks operands on start, computes significands by bit-serial restoring division, then rounds, normalizes and packs in a final cycle. Not pipelined.

Parameters:
- MBITS, 3, fraction width (significand minus hidden bit)
- EBITS, 4, exponent width

Ports:
- clock  input  1  global clock, all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; sampled only in IDLE
- x  input  MBITS+EBITS+1  dividend, packed
- y  input  MBITS+EBITS+1  divisor, packed
- z  output  MBITS+EBITS+1  registered quotient; holds until next result
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse, coincident with z update

Behaviour:
- Reset (async, any state): state=IDLE; z=0, busy=0, done=0; all internal operand, remainder, quotient and counter registers = 0. A division in progress is discarded and no done pulse is issued.
- Classification:
  - exp==0 is zero (fraction ignored; denormals flushed).
  - exp all-ones with frac==0 is infinity.
  - exp all-ones with frac!=0 is NaN.
- IDLE:
  - If start=1, latch sign/exp/{1,frac} of x and y, remainder=dividend significand, count=0, busy=1, go to DIVIDE.
  - Otherwise hold. done=0.
- DIVIDE, one quotient bit per cycle, MBITS+4 cycles:
  - If rem>=divisor significand: qbit=1, rem-=divisor; else qbit=0.
  - Then rem<<=1, q={q,qbit}.
  - rem is MBITS+2 bits wide.
  - After the last bit go to POST.
- POST:
  - q is MBITS+4 bits and q[MBITS+3] is the integer bit.
  - If q[MBITS+3]=1: significand=q[MBITS+3:3], guard=q[2], sticky=q[1]|q[0]|(rem!=0). Otherwise use q shifted left by 1 and decrement the exponent.
  - Round to nearest even: increment if guard&(sticky|lsb).
  - A rounding carry out renormalizes: exponent+1, fraction=0.
  - Exponent is computed in EBITS+2 bits, signed: xExp - yExp + (2^(EBITS-1)-1), with the adjustments above.
  - Sign = xSign^ySign.
- Result priority in POST:
  1. NaN if either operand is NaN, or 0/0, or inf/inf → {0, all-ones exp, all-ones frac}.
  2. Infinity if x is infinity or y is zero → {sign, all-ones exp, 0}.
  3. Zero if x is zero or y is infinity → {sign, 0}.
  4. Underflow if exponent is negative or 0 → signed zero.
  5. Overflow if exponent >= all-ones → signed infinity.
  6. Otherwise the normal packed result.
- POST writes z, sets done=1 and busy=0, and returns to IDLE.
- Latency: with start sampled at edge 0, z and done update at edge MBITS+5 (8 with the defaults). Special cases take the same fixed latency.
- start while busy is ignored and not queued. start in the cycle done=1 is not sampled (POST state); the earliest new acceptance is the following edge.
- x and y are sampled only at acceptance; later changes have no effect.

Decomposition:
- Shared package fp_pkg holds:
  - MBITS/EBITS defaults and BIAS = 2^(EBITS-1)-1
  - the NaN, infinity and zero encoding constants
  - classification functions (is_nan, is_inf, is_zero) and the state encoding (IDLE, DIVIDE, POST)
- The multiplier is to be migrated to fp_pkg.
- One sub-module: fp_mant_div_step, the combinational compare/subtract/shift for one restoring step (rem, divisor → next rem, qbit).

Test Plan (defaults, bias 7):
- 0x4C (6.0) / 0x40 (2.0), start pulsed 1 cycle → busy for 8 cycles, z=0x44 (3.0), done for exactly 1 cycle at edge 8.
- 0x38 (1.0) / 0x44 (3.0) → z=0x2B (1.375·2^-2; exercises round-up via sticky). 0xB8 (-1.0) / 0x40 → z=0xB0 (-0.5).
- Special cases:
  - 0x38/0x00 → 0x78
  - 0x00/0x00 → 0x7F
  - 0x78/0x78 → 0x7F
  - 0x00/0x78 → 0x00
  - 0x79/0x38 → 0x7F
- Range limits: 0x77/0x08 (overflow) → 0x78. 0x08/0x77 (underflow) → 0x00. 0xF7/0x08 → 0xF8.
- Handshake: start held high continuously with changing x,y → results correspond to operands at each acceptance edge (every 9 cycles). Mid-divide x/y changes do not alter z.
- Reset asserted asynchronously mid-DIVIDE → z, busy, done go 0 immediately with no done pulse. After release, a new start gives a correct result at edge 8.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point units.
// Packed format is sign | exponent | fraction, with a hidden leading one.
package fp_pkg;

    localparam int DEF_MBITS = 3;
    localparam int DEF_EBITS = 4;
    localparam int DEF_W     = DEF_MBITS + DEF_EBITS + 1;
    localparam int BIAS      = (1 << (DEF_EBITS - 1)) - 1;

    localparam logic [DEF_W-1:0] NAN_DEF  = {1'b0, {DEF_EBITS{1'b1}}, {DEF_MBITS{1'b1}}};
    localparam logic [DEF_W-1:0] INF_DEF  = {1'b0, {DEF_EBITS{1'b1}}, {DEF_MBITS{1'b0}}};
    localparam logic [DEF_W-1:0] ZERO_DEF = '0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIVIDE = 2'd1;
    localparam logic [1:0] POST   = 2'd2;

    // Callers pass pre-reduced exponent flags so these work for any field width.
    function automatic logic is_nan(input logic exp_ones, input logic frac_nz);
        return exp_ones & frac_nz;
    endfunction

    function automatic logic is_inf(input logic exp_ones, input logic frac_nz);
        return exp_ones & ~frac_nz;
    endfunction

    function automatic logic is_zero(input logic exp_zero);
        return exp_zero;
    endfunction

endpackage

// File: rtl/fp_mant_div_step.sv
// One restoring-division step: conditional subtract of the divisor, then shift left.
module fp_mant_div_step #(
    parameter int MBITS = 3
) (
    input  logic [MBITS+1:0] rem,
    input  logic [MBITS:0]   divisor,
    output logic [MBITS+1:0] rem_next,
    output logic             qbit
);

    always_comb begin
        qbit = (rem >= {1'b0, divisor});
        if (qbit) begin
            rem_next = (rem - {1'b0, divisor}) << 1;
        end else begin
            rem_next = rem << 1;
        end
    end

endmodule

// File: rtl/ieee_fp_div.sv
// Sequential floating-point divider z = x / y, one quotient bit per cycle.
// IDLE: wait for start | DIVIDE: restoring steps | POST: round, classify, pack
module ieee_fp_div #(
    parameter int MBITS = fp_pkg::DEF_MBITS,
    parameter int EBITS = fp_pkg::DEF_EBITS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MBITS+EBITS:0] x,
    input  logic [MBITS+EBITS:0] y,
    output logic [MBITS+EBITS:0] z,
    output logic                 busy,
    output logic                 done
);
    import fp_pkg::*;

    localparam int W  = MBITS + EBITS + 1;
    localparam int QW = MBITS + 4;
    localparam int CW = $clog2(QW);
    localparam int XW = EBITS + 2;

    localparam logic [EBITS-1:0]      EXP_ONES = '1;
    localparam logic signed [XW-1:0]  BIAS_X   = XW'((1 << (EBITS - 1)) - 1);
    localparam logic signed [XW-1:0]  EXP_MAX  = XW'((1 << EBITS) - 1);
    localparam logic signed [XW-1:0]  ONE_X    = XW'(1);
    localparam logic signed [XW-1:0]  ZERO_X   = '0;
    localparam logic [CW-1:0]         LAST_CNT = CW'(QW - 1);

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic             sign_x, sign_y;
    logic [EBITS-1:0] exp_x, exp_y;
    logic [MBITS-1:0] frac_x;
    logic [MBITS:0]   sig_y;
    logic [MBITS+1:0] rem;
    logic [QW-1:0]    q;

    logic [MBITS+1:0] rem_next;
    logic             qbit;

    fp_mant_div_step #(.MBITS(MBITS)) u_step (
        .rem      (rem),
        .divisor  (sig_y),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    logic [QW-2:0]          q_norm;
    logic signed [XW-1:0]   exp_unb, exp_fin;
    logic [MBITS-1:0]       frac_trunc, frac_fin;
    logic [MBITS:0]         frac_round;
    logic                   guard, sticky, round_up;
    logic                   x_nan, x_inf, x_zero, y_nan, y_inf, y_zero;
    logic                   sign_z;
    logic [W-1:0]           z_next;

    always_comb begin
        // Quotient lies in (0.5, 2); drop the integer bit after normalizing.
        q_norm  = q[QW-1] ? q[QW-2:0] : {q[QW-3:0], 1'b0};
        exp_unb = $signed({2'b00, exp_x}) - $signed({2'b00, exp_y}) + BIAS_X;
        if (!q[QW-1]) begin
            exp_unb = exp_unb - ONE_X;
        end

        frac_trunc = q_norm[QW-2:3];
        guard      = q_norm[2];
        sticky     = (|q_norm[1:0]) | (|rem);
        round_up   = guard & (sticky | frac_trunc[0]);
        frac_round = {1'b0, frac_trunc} + {{MBITS{1'b0}}, round_up};

        exp_fin  = exp_unb;
        frac_fin = frac_round[MBITS-1:0];
        if (frac_round[MBITS]) begin
            exp_fin  = exp_unb + ONE_X;
            frac_fin = '0;
        end

        x_nan  = is_nan(&exp_x, |frac_x);
        x_inf  = is_inf(&exp_x, |frac_x);
        x_zero = is_zero(~|exp_x);
        y_nan  = is_nan(&exp_y, |sig_y[MBITS-1:0]);
        y_inf  = is_inf(&exp_y, |sig_y[MBITS-1:0]);
        y_zero = is_zero(~|exp_y);
        sign_z = sign_x ^ sign_y;

        if (x_nan | y_nan | (x_zero & y_zero) | (x_inf & y_inf)) begin
            z_next = {1'b0, EXP_ONES, {MBITS{1'b1}}};
        end else if (x_inf | y_zero) begin
            z_next = {sign_z, EXP_ONES, {MBITS{1'b0}}};
        end else if (x_zero | y_inf) begin
            z_next = {sign_z, {(W-1){1'b0}}};
        end else if (exp_fin <= ZERO_X) begin
            z_next = {sign_z, {(W-1){1'b0}}};
        end else if (exp_fin >= EXP_MAX) begin
            z_next = {sign_z, EXP_ONES, {MBITS{1'b0}}};
        end else begin
            z_next = {sign_z, exp_fin[EBITS-1:0], frac_fin};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            sign_x <= 1'b0;
            sign_y <= 1'b0;
            exp_x  <= '0;
            exp_y  <= '0;
            frac_x <= '0;
            sig_y  <= '0;
            rem    <= '0;
            q      <= '0;
            z      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_x <= x[W-1];
                        exp_x  <= x[W-2:MBITS];
                        frac_x <= x[MBITS-1:0];
                        sign_y <= y[W-1];
                        exp_y  <= y[W-2:MBITS];
                        sig_y  <= {1'b1, y[MBITS-1:0]};
                        rem    <= {2'b01, x[MBITS-1:0]};
                        q      <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem   <= rem_next;
                    q     <= {q[QW-2:0], qbit};
                    count <= count + CW'(1);
                    if (count == LAST_CNT) begin
                        state <= POST;
                    end
                end
                POST: begin
                    z     <= z_next;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
